boolean_function_1b: RTL and testbench

Three-input Boolean function block computing d = (a AND NOT b) OR c. It is used as a leaf combinational cell in the week-5 logic labs. The block also provides:
- a registered copy of the result,
- a one-hot minterm decode,
- a saturating count of cycles with a registered-high result.

These extras let downstream synchronous logic and on-board debug observe the function without glitches.

---
 rtl/boolean_function_1b.sv | 52 +++++
 tb/tb_boolean_function_1b.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/boolean_function_1b.sv
// Three-input function d = (a & ~b) | c with a registered copy, a one-hot
// minterm decode and a saturating count of cycles where the registered result was high.
module boolean_function_1b #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             d,
  output logic             d_q,
  output logic [7:0]       minterm,
  output logic [CNT_W-1:0] hi_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic             dreg_q;
  logic             dreg_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    d       = (a & ~b) | c;
    minterm = 8'b0000_0001 << {a, b, c};
  end

  // The counter looks at the registered result from before this edge, so it lags d_q by one cycle.
  always_comb begin
    dreg_d = d;
    cnt_d  = cnt_q;
    if (dreg_q && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dreg_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      dreg_q <= dreg_d;
      cnt_q  <= cnt_d;
    end
  end

  assign d_q    = dreg_q;
  assign hi_cnt = cnt_q;

endmodule

// File: tb/tb_boolean_function_1b.sv
// Scoreboard bench for boolean_function_1b: a default-width instance and a
// 4-bit-counter instance share the same inputs and are checked against a truth-table model.
module tb_boolean_function_1b;

  typedef struct {
    logic       d;
    logic [7:0] mt;
  } comb_exp_t;

  typedef struct {
    logic       dq;
    logic [7:0] cnt;
    logic [3:0] cnt4;
  } reg_exp_t;

  localparam logic [7:0] TruthTable = 8'b1011_1010;

  logic       clk;
  logic       rst;
  logic       a, b, c;
  logic       d, d_q;
  logic [7:0] minterm;
  logic [7:0] hi_cnt;
  logic       d4, d_q4;
  logic [7:0] minterm4;
  logic [3:0] hi_cnt4;

  int checks = 0;
  int errors = 0;

  comb_exp_t comb_q[$];
  reg_exp_t  reg_q[$];

  logic       m_dq   = 1'b0;
  logic [7:0] m_cnt  = '0;
  logic [3:0] m_cnt4 = '0;

  boolean_function_1b #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
    .d(d), .d_q(d_q), .minterm(minterm), .hi_cnt(hi_cnt)
  );

  boolean_function_1b #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
    .d(d4), .d_q(d_q4), .minterm(minterm4), .hi_cnt(hi_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive inputs, queue the combinational expectation, then compare it once the outputs settle.
  task automatic applyStimulus(input logic [2:0] abc);
    comb_exp_t e;
    comb_exp_t got;
    {a, b, c} = abc;
    e.d  = TruthTable[abc];
    e.mt = 8'h00;
    e.mt[abc] = 1'b1;
    comb_q.push_back(e);
    #1;
    got = comb_q.pop_front();
    checkOutput("d", {31'd0, d}, {31'd0, got.d});
    checkOutput("minterm", {24'd0, minterm}, {24'd0, got.mt});
    checkOutput("d4", {31'd0, d4}, {31'd0, got.d});
    checkOutput("d_or_minterms", {31'd0, d}, {31'd0, |(minterm & TruthTable)});
  endtask

  // Reference model for the registered outputs; each edge pushes what should be visible afterwards.
  always @(posedge clk) begin
    reg_exp_t e;
    if (rst) begin
      m_dq = 1'b0; m_cnt = '0; m_cnt4 = '0;
    end else begin
      if (m_dq && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      if (m_dq && m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
      m_dq = TruthTable[{a, b, c}];
    end
    e.dq = m_dq; e.cnt = m_cnt; e.cnt4 = m_cnt4;
    reg_q.push_back(e);
  end

  // Asynchronous reset wipes pending expectations: the registers clear immediately.
  always @(posedge rst) begin
    reg_exp_t e;
    m_dq = 1'b0; m_cnt = '0; m_cnt4 = '0;
    reg_q.delete();
    e.dq = 1'b0; e.cnt = '0; e.cnt4 = '0;
    reg_q.push_back(e);
  end

  always @(negedge clk) begin
    reg_exp_t e;
    while (reg_q.size() > 0) begin
      e = reg_q.pop_front();
      checkOutput("sb_d_q", {31'd0, d_q}, {31'd0, e.dq});
      checkOutput("sb_hi_cnt", {24'd0, hi_cnt}, {24'd0, e.cnt});
      checkOutput("sb_d_q4", {31'd0, d_q4}, {31'd0, e.dq});
      checkOutput("sb_hi_cnt4", {28'd0, hi_cnt4}, {28'd0, e.cnt4});
    end
  end

  initial begin
    rst = 1'b1;
    {a, b, c} = 3'b000;
    #1;
    checkOutput("reset_d_q", {31'd0, d_q}, 32'd0);
    checkOutput("reset_hi_cnt", {24'd0, hi_cnt}, 32'd0);

    // Exhaustive sweep in 2 ns slots while reset is held; d must not care about rst.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(3'(i));
      #1;
    end

    @(negedge clk);
    rst = 1'b0;
    applyStimulus(3'b100);
    @(posedge clk); #1;
    checkOutput("regpath_first_edge", {31'd0, d_q}, 32'd1);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    applyStimulus(3'b110);
    @(posedge clk); #1;
    checkOutput("regpath_after_110", {31'd0, d_q}, 32'd0);

    @(negedge clk);
    applyStimulus(3'b001);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pre_reset_d_q", {31'd0, d_q}, 32'd1);
    checkOutput("pre_reset_hi_cnt", {24'd0, hi_cnt}, 32'd5);

    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_d_q", {31'd0, d_q}, 32'd0);
    checkOutput("async_hi_cnt", {24'd0, hi_cnt}, 32'd0);
    applyStimulus(3'b010);
    applyStimulus(3'b101);

    @(negedge clk);
    rst = 1'b0;
    applyStimulus(3'b001);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("count_10_edges", {24'd0, hi_cnt}, 32'd9);

    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i >= 15) checkOutput("sat_cnt4", {28'd0, hi_cnt4}, 32'd15);
    end
    checkOutput("cnt8_after_30", {24'd0, hi_cnt}, 32'd29);

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      applyStimulus(3'($urandom_range(0, 7)));
    end
    @(posedge clk);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
